// File: rtl/pattern_burst_arbiter.sv
// Two-requester round-robin arbiter that hands an 8-word pattern generator to one owner per burst.
// Define PATTERN_ARB_RESYNC_EN to restart the generator during every GRANT cycle.
module pattern_burst_arbiter #(
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic [1:0]       i_req,
    input  logic [LEN_W-1:0] i_len0,
    input  logic [LEN_W-1:0] i_len1,
    output logic [1:0]       o_grant,
    output logic [1:0]       o_done,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [7:0]       o_out_data,
    output logic             o_out_last,
    input  logic [7:0]       i_gen_data,
    output logic             o_gen_enable,
    output logic             o_gen_rst_n,
    output logic             o_busy
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, GRANT, BURST, GAP} state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [LEN_W-1:0] r_cnt;
    logic             r_rr;
    logic             r_owner;
    logic [1:0]       r_grant;
    logic [1:0]       r_done;
    logic [GAP_W-1:0] r_gap;
    logic             w_winner;
    logic [LEN_W-1:0] w_len_sel;
    logic             w_hs;
    logic             w_last_hs;

    // r_rr == 0 favours requester 0; the other requester only wins when the favoured one is idle
    assign w_winner  = r_rr ? i_req[1] : ~i_req[0];
    assign w_len_sel = w_winner ? i_len1 : i_len0;
    assign w_hs      = (r_state == BURST) && i_out_ready;
    assign w_last_hs = w_hs && (r_cnt == LEN_W'(1));

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= IDLE;
        else            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        o_out_valid  = 1'b0;
        o_out_data   = '0;
        o_out_last   = 1'b0;
        o_gen_enable = 1'b0;
        o_busy       = (r_state != IDLE);
        case (r_state)
            IDLE:  if (|i_req) w_next_state = GRANT;
            GRANT: w_next_state = BURST;
            BURST: begin
                o_out_valid  = 1'b1;
                o_out_data   = i_gen_data;
                o_out_last   = (r_cnt == LEN_W'(1));
                o_gen_enable = w_hs;
                if (w_last_hs) w_next_state = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
            GAP:   if (r_gap == '0) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_cnt   <= '0;
            r_rr    <= 1'b0;
            r_owner <= 1'b0;
            r_grant <= '0;
            r_done  <= '0;
            r_gap   <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (|i_req) begin
                        r_owner <= w_winner;
                        r_grant <= w_winner ? 2'b10 : 2'b01;
                        r_cnt   <= (w_len_sel == '0) ? LEN_W'(1) : w_len_sel;
                    end
                end
                BURST: begin
                    if (w_hs) begin
                        r_cnt <= r_cnt - LEN_W'(1);
                        if (r_cnt == LEN_W'(1)) begin
                            r_grant <= '0;
                            r_done  <= r_grant;
                            r_rr    <= ~r_owner;
                            r_gap   <= GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign o_grant = r_grant;
    assign o_done  = r_done;

`ifdef PATTERN_ARB_RESYNC_EN
    logic r_gen_rst_n;

    // Low only in the cycle after IDLE->GRANT, so the generator restarts exactly as BURST begins
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_gen_rst_n <= 1'b1;
        else            r_gen_rst_n <= !((r_state == IDLE) && (|i_req));
    end

    assign o_gen_rst_n = r_gen_rst_n;
`else
    assign o_gen_rst_n = 1'b1;
`endif

endmodule

// File: tb/tb_pattern_burst_arbiter.sv
// Scoreboard bench for pattern_burst_arbiter with a behavioural 8-word pattern generator attached.
module tb_pattern_burst_arbiter;

    localparam int unsigned LEN_W = 4;
    localparam int unsigned GAP   = 1;

`ifdef PATTERN_ARB_RESYNC_EN
    localparam logic       EXP_GRANT_RST = 1'b0;
    localparam logic [7:0] EXP_B2_0 = 8'hAF, EXP_B2_1 = 8'hBC;
    localparam logic [7:0] EXP_RR_2 = 8'hAF, EXP_Z    = 8'hAF;
`else
    localparam logic       EXP_GRANT_RST = 1'b1;
    localparam logic [7:0] EXP_B2_0 = 8'h78, EXP_B2_1 = 8'hFF;
    localparam logic [7:0] EXP_RR_2 = 8'hBC, EXP_Z    = 8'hFF;
`endif

    logic             clk = 1'b0;
    logic             reset_n;
    logic [1:0]       req;
    logic [LEN_W-1:0] len0, len1;
    logic             out_ready;
    logic [1:0]       grant, done;
    logic             out_valid, out_last, gen_enable, gen_rst_n, busy;
    logic [7:0]       out_data, gen_data;
    logic [2:0]       gidx = '0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] grant;
    } beat_t;

    beat_t sb[$];
    beat_t mon_e;
    int    n_tests = 0;
    int    n_fail  = 0;

    pattern_burst_arbiter #(.LEN_W(LEN_W), .GAP_CYCLES(GAP)) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_req(req), .i_len0(len0), .i_len1(len1),
        .o_grant(grant), .o_done(done), .o_out_valid(out_valid), .i_out_ready(out_ready),
        .o_out_data(out_data), .o_out_last(out_last), .i_gen_data(gen_data),
        .o_gen_enable(gen_enable), .o_gen_rst_n(gen_rst_n), .o_busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!reset_n || !gen_rst_n) gidx <= '0;
        else if (gen_enable)        gidx <= gidx + 3'd1;
    end

    always_comb begin
        case (gidx)
            3'd0: gen_data = 8'hAF;
            3'd1: gen_data = 8'hBC;
            3'd2: gen_data = 8'hE2;
            3'd3: gen_data = 8'h78;
            3'd4: gen_data = 8'hFF;
            3'd5: gen_data = 8'h13;
            3'd6: gen_data = 8'h5A;
            default: gen_data = 8'hC6;
        endcase
    end

    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_beat: got data=%h last=%b grant=%b, expected no beat", out_data, out_last, grant);
            end else begin
                mon_e = sb.pop_front();
                if ({out_data, out_last, grant, gen_enable} !== {mon_e.data, mon_e.last, mon_e.grant, 1'b1}) begin
                    n_fail++;
                    $display("FAIL beat: got data=%h last=%b grant=%b gen_en=%b, expected data=%h last=%b grant=%b gen_en=1",
                             out_data, out_last, grant, gen_enable, mon_e.data, mon_e.last, mon_e.grant);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0; req = '0; len0 = '0; len1 = '0; out_ready = 1'b1;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_done(output logic [1:0] d);
        d = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done !== 2'b00) begin
                d = done;
                break;
            end
        end
    endtask

    task automatic wait_valid(output logic found);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; req = 2'b11; len0 = 4'd3; len1 = 4'd3; out_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_tests++;
        if ({grant, done, out_valid, out_last, gen_enable, busy, gen_rst_n} !== 9'b0000_0000_1) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, expected 000000001",
                     {grant, done, out_valid, out_last, gen_enable, busy, gen_rst_n});
        end
        req = '0;
        tick();
        reset_n = 1'b1;
        tick();
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy: got %b, expected 0", busy);
        end
    endtask

    task automatic test_basic();
        logic [1:0] d;
        req = 2'b01; len0 = 4'd3; out_ready = 1'b1;
        sb.push_back('{8'hAF, 1'b0, 2'b01});
        sb.push_back('{8'hBC, 1'b0, 2'b01});
        sb.push_back('{8'hE2, 1'b1, 2'b01});
        @(negedge clk);
        n_tests++;
        if ({grant, out_valid, busy} !== 4'b01_0_1) begin
            n_fail++;
            $display("FAIL basic_grant_cycle: got grant=%b valid=%b busy=%b, expected 01 0 1", grant, out_valid, busy);
        end
        req = 2'b00; len0 = 4'd7;
        @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_first_valid: got %b, expected 1", out_valid);
        end
        wait_done(d);
        n_tests++;
        if (d !== 2'b01 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL basic_done: got done=%b pending=%0d, expected done=01 pending=0", d, sb.size());
        end
        n_tests++;
        if (busy !== (GAP > 0)) begin
            n_fail++;
            $display("FAIL basic_gap_busy: got %b, expected %b", busy, (GAP > 0));
        end
        @(negedge clk);
        n_tests++;
        if ({busy, done} !== 3'b0_00) begin
            n_fail++;
            $display("FAIL basic_back_idle: got busy=%b done=%b, expected 0 00", busy, done);
        end
    endtask

    task automatic test_second();
        logic [1:0] d;
        req = 2'b10; len1 = 4'd2;
        sb.push_back('{EXP_B2_0, 1'b0, 2'b10});
        sb.push_back('{EXP_B2_1, 1'b1, 2'b10});
        @(negedge clk);
        n_tests++;
        if ({grant, gen_rst_n} !== {2'b10, EXP_GRANT_RST}) begin
            n_fail++;
            $display("FAIL second_grant: got grant=%b gen_rst_n=%b, expected 10 %b", grant, gen_rst_n, EXP_GRANT_RST);
        end
        req = 2'b00;
        wait_done(d);
        n_tests++;
        if (d !== 2'b10 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL second_done: got done=%b pending=%0d, expected done=10 pending=0", d, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [1:0] first_grant;
        logic       seen2;
        int         gap_cnt;
        first_grant = '0; seen2 = 1'b0; gap_cnt = 0;
        apply_reset();
        req = 2'b11; len0 = 4'd1; len1 = 4'd1;
        sb.push_back('{8'hAF, 1'b1, 2'b01});
        sb.push_back('{EXP_RR_2, 1'b1, 2'b10});
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (first_grant == 2'b00 && grant != 2'b00) first_grant = grant;
            if (first_grant != 2'b00 && !seen2 && busy === 1'b1 && grant === 2'b00) gap_cnt++;
            if (grant === 2'b10 && !seen2) begin
                seen2 = 1'b1;
                req = 2'b00;
            end
            if (seen2 && busy === 1'b0) break;
        end
        n_tests++;
        if (first_grant !== 2'b01 || seen2 !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_order: got first=%b second_seen=%b, expected 01 1", first_grant, seen2);
        end
        n_tests++;
        if (gap_cnt != int'(GAP) || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rr_gap: got gap=%0d pending=%0d, expected gap=%0d pending=0", gap_cnt, sb.size(), GAP);
        end
    endtask

    task automatic test_stall();
        logic [1:0] d;
        logic       found;
        int         bad;
        bad = 0;
        apply_reset();
        req = 2'b01; len0 = 4'd4;
        sb.push_back('{8'hAF, 1'b0, 2'b01});
        sb.push_back('{8'hBC, 1'b0, 2'b01});
        sb.push_back('{8'hE2, 1'b0, 2'b01});
        sb.push_back('{8'h78, 1'b1, 2'b01});
        wait_valid(found);
        req = 2'b00;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if ({out_data, gen_enable, out_valid, out_last} !== {8'hBC, 1'b0, 1'b1, 1'b0}) bad++;
        end
        n_tests++;
        if (found !== 1'b1 || bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got found=%b bad_cycles=%0d (data=%h gen_en=%b), expected found=1 bad=0 data=bc gen_en=0",
                     found, bad, out_data, gen_enable);
        end
        out_ready = 1'b1;
        wait_done(d);
        n_tests++;
        if (d !== 2'b01 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL stall_done: got done=%b pending=%0d, expected done=01 pending=0", d, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_len_zero();
        logic [1:0] d;
        int         beats;
        d = '0; beats = 0;
        req = 2'b01; len0 = 4'd0;
        sb.push_back('{EXP_Z, 1'b1, 2'b01});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (grant !== 2'b00) req = 2'b00;
            if (out_valid === 1'b1 && out_ready === 1'b1) beats++;
            if (done !== 2'b00) begin
                d = done;
                break;
            end
        end
        req = 2'b00;
        n_tests++;
        if (d !== 2'b01 || beats != 1 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL len_zero: got done=%b beats=%0d pending=%0d, expected done=01 beats=1 pending=0", d, beats, sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic found;
        logic any_done;
        any_done = 1'b0;
        apply_reset();
        req = 2'b01; len0 = 4'd4;
        sb.push_back('{8'hAF, 1'b0, 2'b01});
        wait_valid(found);
        req = 2'b00;
        tick();
        reset_n = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        n_tests++;
        if (found !== 1'b1 || {out_valid, out_data} !== {1'b1, 8'hBC}) begin
            n_fail++;
            $display("FAIL rstmid_beat2: got found=%b valid=%b data=%h, expected 1 1 bc", found, out_valid, out_data);
        end
        @(negedge clk);
        n_tests++;
        if ({grant, done, out_valid, out_last, gen_enable, busy, out_data, gen_rst_n} !== {9'b0, 8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got grant=%b done=%b valid=%b last=%b gen_en=%b busy=%b data=%h gen_rst_n=%b, expected all 0, gen_rst_n=1",
                     grant, done, out_valid, out_last, gen_enable, busy, out_data, gen_rst_n);
        end
        reset_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done !== 2'b00) any_done = 1'b1;
        end
        n_tests++;
        if (any_done !== 1'b0 || busy !== 1'b0 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got any_done=%b busy=%b pending=%0d, expected 0 0 0", any_done, busy, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; req = '0; len0 = '0; len1 = '0; out_ready = 1'b1;
        test_reset();
        test_basic();
        test_second();
        test_round_robin();
        test_stall();
        test_len_zero();
        test_reset_mid();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending beats, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pattern_burst_arbiter.md
PATTERN_BURST_ARBITER -- requirements
Module: pattern_burst_arbiter

Interface
REQ-001 Parameter LEN_W, default 4, sets the width of the burst-length inputs and the beat counter.
REQ-002 Parameter GAP_CYCLES, default 1, sets the idle cycles inserted after each burst (0 = none).
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 req  input  2  per-requester burst request, level-sensitive.
REQ-006 len0 / len1  input  LEN_W each  burst length in beats for requester 0 / 1.
REQ-007 grant  output  2  one-hot owner of the pattern generator.
REQ-008 done  output  2  one-cycle pulse per requester on burst completion.
REQ-009 out_valid / out_ready  output / input  1 / 1  beat handshake to the owner.
REQ-010 out_data  output  8  beat data, equal to gen_data.
REQ-011 out_last  output  1  marks the final beat of a burst.
REQ-012 gen_data  input  8  current word from the attached 8-word sequence generator.
REQ-013 gen_enable  output  1  advance strobe to the generator.
REQ-014 gen_rst_n  output  1  registered active-low restart to the generator.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT, BURST and GAP.
REQ-017 IDLE→GRANT SHALL occur when any req bit is sampled high; otherwise the FSM stays in IDLE.
REQ-018 Selection SHALL be round-robin: after a burst for requester i, requester 1-i has priority; after reset, requester 0 has priority.
REQ-019 On IDLE→GRANT the winner's len SHALL be latched into the beat counter; a latched value of 0 SHALL be treated as 1.
REQ-020 GRANT SHALL last exactly one cycle, then the FSM SHALL move to BURST.
REQ-021 grant[i] SHALL be registered, high from GRANT entry through the cycle of the last BURST handshake, and SHALL be zero otherwise.
REQ-022 In BURST, out_valid SHALL be 1 and out_data SHALL equal gen_data combinationally; outside BURST both SHALL be 0.
REQ-023 gen_enable SHALL equal out_valid & out_ready, so the generator advances exactly once per accepted beat.
REQ-024 Each handshake SHALL decrement the counter, and out_last SHALL be 1 while the counter equals 1.
REQ-025 On the last handshake, done[i] SHALL pulse in the following cycle, and the FSM SHALL go to GAP, or to IDLE when GAP_CYCLES=0.
REQ-026 GAP SHALL last exactly GAP_CYCLES cycles, then return to IDLE; req is ignored during GAP.
REQ-027 With out_ready low, out_data, out_last and the counter SHALL hold and gen_enable SHALL be 0.
REQ-028 Deasserting req mid-burst SHALL NOT abort the burst, and changes to len0/len1 after latching SHALL be ignored.
REQ-029 First out_valid SHALL occur two cycles after req is sampled high in IDLE.

Reset
REQ-030 While reset_n is low at posedge clk, the FSM SHALL enter IDLE with the counter at 0 and the round-robin pointer at requester 0.
REQ-031 During reset, grant, done, out_valid, out_last, gen_enable and busy SHALL be 0 and gen_rst_n SHALL be 1.
REQ-032 Reset mid-burst SHALL abandon the burst without asserting done.

Configuration
REQ-033 Macro PATTERN_ARB_RESYNC_EN SHALL control whether each burst restarts the pattern.
REQ-034 With PATTERN_ARB_RESYNC_EN defined, gen_rst_n SHALL be 0 for exactly the GRANT cycle, so every burst starts at 0xAF.
REQ-035 Without PATTERN_ARB_RESYNC_EN, gen_rst_n SHALL be constant 1 and the pattern SHALL continue across bursts.

Verification
REQ-036 Bench SHALL drive: no macro, after reset, req0=1, len0=3, out_ready=1 -> beats AF, BC, E2 with out_last on E2, then done[0] pulse.
REQ-037 Bench SHALL drive: no macro, next req1=1, len1=2 -> beats 78, FF; with macro defined -> AF, BC.
REQ-038 Bench SHALL drive: req=2'b11 from reset, len0=len1=1 -> grant 01 then 10, with GAP_CYCLES idle cycles between bursts.
REQ-039 Bench SHALL drive: out_ready low for 3 cycles mid-burst -> out_data held, gen_enable 0, burst completes after out_ready rises.
REQ-040 Bench SHALL drive: len0=0 -> exactly one beat with out_last=1.
REQ-041 Bench SHALL drive: reset_n low during beat 2 of a 4-beat burst -> next cycle all outputs 0, no done, FSM in IDLE.
